// File: rtl/serial_sum_collector_pkg.sv
// Shared types and helpers for the bit-serial sum collector.
package serial_pkg;

   typedef enum logic [1:0] {
      IDLE,
      SHIFT,
      HOLD
   } state_t;

   localparam int unsigned DEFAULT_WIDTH = 16;

   // One extra bit so the beat counter can represent WIDTH itself.
   function automatic int unsigned cnt_width(input int unsigned w);
      return $clog2(w) + 1;
   endfunction

endpackage

// File: rtl/serial_sum_collector_if.sv
// Serial bit-pair input and parallel sum output handshakes.
// Optional `SERIAL_SUM_OVF_EN adds the signed overflow flag.
interface serial_sum_collector_if #(
   parameter int unsigned WIDTH = serial_pkg::DEFAULT_WIDTH
);
   logic             bit_valid;
   logic             bit_a;
   logic             bit_b;
   logic             bit_ready;
   logic [WIDTH-1:0] sum_data;
   logic             carry_out;
   logic             sum_valid;
   logic             sum_ready;
`ifdef SERIAL_SUM_OVF_EN
   logic             overflow;

   modport master (
      output bit_valid, bit_a, bit_b, sum_ready,
      input  bit_ready, sum_data, carry_out, sum_valid, overflow
   );
   modport slave (
      input  bit_valid, bit_a, bit_b, sum_ready,
      output bit_ready, sum_data, carry_out, sum_valid, overflow
   );
`else
   modport master (
      output bit_valid, bit_a, bit_b, sum_ready,
      input  bit_ready, sum_data, carry_out, sum_valid
   );
   modport slave (
      input  bit_valid, bit_a, bit_b, sum_ready,
      output bit_ready, sum_data, carry_out, sum_valid
   );
`endif
endinterface

// File: rtl/serial_sum_collector_sipo_shift.sv
// Serial-in parallel-out shift register, mirror of the PISO: new bit enters the MSB.
module sipo_shift #(
   parameter int unsigned WIDTH = serial_pkg::DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             en,
   input  logic             din,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] r_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_q <= '0;
      end else if (clr) begin
         r_q <= '0;
      end else if (en) begin
         r_q <= {din, r_q[WIDTH-1:1]};
      end
   end

   assign q = r_q;

endmodule

// File: rtl/serial_sum_collector.sv
// Bit-serial adder receive end: LSB-first bit pairs in, WIDTH-bit sum word out.
// Optional `SERIAL_SUM_OVF_EN adds a registered two's-complement overflow output.
module serial_sum_collector
   import serial_pkg::*;
#(
   parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   start,
   output logic                   busy,
   serial_sum_collector_if.slave  bus
);

   localparam int unsigned     CW   = cnt_width(WIDTH);
   localparam logic [CW-1:0]   LAST = CW'(WIDTH - 1);

   state_t           r_state;
   state_t           w_next;
   logic             r_carry;
   logic [CW-1:0]    r_count;
   logic [WIDTH-1:0] r_sum;
   logic             r_cout;
   logic             r_valid;
   logic [WIDTH-1:0] w_shreg;
   logic             w_ready;
   logic             w_clr;
   logic             w_beat;
   logic             w_last;
   logic             w_s;
   logic             w_maj;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next  = r_state;
      w_ready = 1'b0;
      w_clr   = 1'b0;
      case (r_state)
         IDLE: begin
            if (start) begin
               w_next = SHIFT;
               w_clr  = 1'b1;
            end
         end
         SHIFT: begin
            w_ready = 1'b1;
            // start aborts the frame and wins over any bit pair offered this cycle
            if (start) begin
               w_clr = 1'b1;
            end else if (bus.bit_valid && (r_count == LAST)) begin
               w_next = HOLD;
            end
         end
         HOLD: begin
            if (bus.sum_ready) begin
               if (start) begin
                  w_next = SHIFT;
                  w_clr  = 1'b1;
               end else begin
                  w_next = IDLE;
               end
            end
         end
         default: w_next = IDLE;
      endcase
   end

   assign w_beat = w_ready & bus.bit_valid & ~start;
   assign w_last = w_beat & (r_count == LAST);
   assign w_s    = bus.bit_a ^ bus.bit_b ^ r_carry;
   assign w_maj  = (bus.bit_a & bus.bit_b) | (bus.bit_a & r_carry) | (bus.bit_b & r_carry);

   sipo_shift #(.WIDTH(WIDTH)) u_sipo (
      .clk (clk),
      .rst (rst),
      .clr (w_clr),
      .en  (w_beat),
      .din (w_s),
      .q   (w_shreg)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_carry <= 1'b0;
         r_count <= '0;
      end else if (w_clr) begin
         r_carry <= 1'b0;
         r_count <= '0;
      end else if (w_beat) begin
         r_carry <= w_maj;
         r_count <= r_count + CW'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_sum   <= '0;
         r_cout  <= 1'b0;
         r_valid <= 1'b0;
      end else if (w_last) begin
         r_sum   <= {w_s, w_shreg[WIDTH-1:1]};
         r_cout  <= w_maj;
         r_valid <= 1'b1;
      end else if ((r_state == HOLD) && bus.sum_ready) begin
         r_valid <= 1'b0;
      end
   end

`ifdef SERIAL_SUM_OVF_EN
   logic r_ovf;

   // On the final beat r_carry is the carry into the MSB, w_maj the carry out of it.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_ovf <= 1'b0;
      end else if (w_last) begin
         r_ovf <= r_carry ^ w_maj;
      end
   end

   assign bus.overflow = r_ovf;
`endif

   assign bus.bit_ready = w_ready;
   assign bus.sum_data  = r_sum;
   assign bus.carry_out = r_cout;
   assign bus.sum_valid = r_valid;
   assign busy          = (r_state != IDLE);

endmodule
